// File: rtl/time_edit.sv
// Digit editor for the alarm-clock set modes: edits a BCD HH:MM working copy
// digit by digit, commits it with a one-cycle strobe and drives blink enables.
module time_edit #(
    parameter int BLINK_TICKS = 250
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        edit_start,
    input  logic        edit_done,
    input  logic        up,
    input  logic        down,
    input  logic [1:0]  pos,
    input  logic [15:0] cur_time,
    output logic [15:0] edit_time,
    output logic        editing,
    output logic        commit,
    output logic [3:0]  digit_on
);

    localparam int CNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_TICKS - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EDIT   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [1:0]       state;
    logic             blink_phase;
    logic [CNT_W-1:0] blink_cnt;
    logic             step_req;
    logic [3:0]       ht, hu, mt, mu;
    logic [3:0]       sel_digit, sel_max, new_digit;
    logic [15:0]      edited;

    // Largest legal value of the digit at cursor p; hour units depend on hour tens.
    function automatic logic [3:0] digit_max(input logic [1:0] p, input logic [3:0] h_tens);
        case (p)
            2'd0:    return 4'd2;
            2'd1:    return (h_tens == 4'd2) ? 4'd3 : 4'd9;
            2'd2:    return 4'd5;
            default: return 4'd9;
        endcase
    endfunction

    // Wrap-around increment; an out-of-range digit also lands on 0.
    function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] mx);
        return (d >= mx) ? 4'd0 : d + 4'd1;
    endfunction

    // Wrap-around decrement; an out-of-range digit lands on the maximum.
    function automatic logic [3:0] digit_dec(input logic [3:0] d, input logic [3:0] mx);
        return ((d == 4'd0) || (d > mx)) ? mx : d - 4'd1;
    endfunction

    assign ht = edit_time[15:12];
    assign hu = edit_time[11:8];
    assign mt = edit_time[7:4];
    assign mu = edit_time[3:0];

    // Simultaneous up and down cancel out.
    assign step_req = up ^ down;

    always_comb begin
        sel_digit = 4'd0;
        case (pos)
            2'd0:    sel_digit = ht;
            2'd1:    sel_digit = hu;
            2'd2:    sel_digit = mt;
            default: sel_digit = mu;
        endcase
        sel_max   = digit_max(pos, ht);
        new_digit = up ? digit_inc(sel_digit, sel_max) : digit_dec(sel_digit, sel_max);

        edited = edit_time;
        case (pos)
            2'd0: begin
                edited[15:12] = new_digit;
                // Moving into the 20s must not leave an illegal 24..29 hour.
                if ((new_digit == 4'd2) && (hu > 4'd3))
                    edited[11:8] = 4'd3;
            end
            2'd1:    edited[11:8] = new_digit;
            2'd2:    edited[7:4]  = new_digit;
            default: edited[3:0]  = new_digit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            edit_time   <= 16'h0000;
            editing     <= 1'b0;
            commit      <= 1'b0;
            blink_phase <= 1'b1;
            blink_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    edit_time   <= cur_time;
                    commit      <= 1'b0;
                    blink_phase <= 1'b1;
                    blink_cnt   <= '0;
                    if (edit_start) begin
                        state   <= EDIT;
                        editing <= 1'b1;
                    end
                end
                EDIT: begin
                    if (edit_done) begin
                        state   <= COMMIT;
                        editing <= 1'b0;
                        commit  <= 1'b1;
                    end else if (step_req) begin
                        edit_time   <= edited;
                        blink_phase <= 1'b1;
                        blink_cnt   <= '0;
                    end else if (tick) begin
                        if (blink_cnt == CNT_LAST) begin
                            blink_cnt   <= '0;
                            blink_phase <= ~blink_phase;
                        end else begin
                            blink_cnt <= blink_cnt + CNT_W'(1);
                        end
                    end
                end
                COMMIT: begin
                    state     <= IDLE;
                    commit    <= 1'b0;
                    edit_time <= cur_time;
                end
                default: begin
                    state   <= IDLE;
                    editing <= 1'b0;
                    commit  <= 1'b0;
                end
            endcase
        end
    end

    // Only the digit under the cursor blinks.
    always_comb begin
        digit_on = 4'b1111;
        if (state == EDIT)
            digit_on[~pos] = blink_phase;
    end

endmodule

// File: doc/time_edit.md
# time_edit

Digit editor for the alarm-clock set modes; sits directly downstream of the cursor-position counter. Takes the 2-bit cursor position plus up/down button pulses and edits a 4-digit BCD HH:MM working copy under 24-hour range rules. It snapshots the live time on entry, emits a one-cycle commit strobe with the edited value on exit, and drives per-digit blink enables for the seven-segment driver.

## Interface
- BLINK_TICKS, default 250: `tick` pulses per blink half-period, minimum 1.
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- tick  in  1  single-cycle timebase enable for blinking
- edit_start  in  1  single-cycle pulse: enter edit mode
- edit_done  in  1  single-cycle pulse: leave edit mode and commit
- up  in  1  single-cycle pulse: increment the selected digit
- down  in  1  single-cycle pulse: decrement the selected digit
- pos  in  2  cursor: 0=hour tens, 1=hour units, 2=minute tens, 3=minute units
- cur_time  in  16  live time, BCD {Ht[3:0],Hu[3:0],Mt[3:0],Mu[3:0]}
- edit_time  out  16  working copy, same packing as cur_time
- editing  out  1  high in EDIT state
- commit  out  1  one-cycle strobe; edit_time is valid to load in that cycle
- digit_on  out  4  per-digit display enable, bit3=Ht … bit0=Mu

## Operation
- FSM states: IDLE, EDIT, COMMIT.
- IDLE: edit_time <= cur_time every cycle. up/down/edit_done ignored. edit_start -> EDIT; edit_time holds the cur_time sampled on that edge.
- EDIT: at most one digit change per cycle on the digit selected by pos.
  - up only: increment; value at max goes to 0. down only: decrement; 0 goes to max.
  - up and down together: no change.
  - Max values: Ht=2, Hu=9 (3 when Ht=2), Mt=5, Mu=9.
  - If the selected digit is already above its max (out-of-range load): up -> 0, down -> max.
  - Ht change to 2 while Hu>3: Hu clamped to 3 on the same edge.
  - edit_start ignored.
  - edit_done -> COMMIT; up/down in the same cycle ignored.
- COMMIT: lasts exactly one cycle; commit=1, edit_time holds the final value; next state IDLE.
- Blink: blink_phase register plus a tick counter 0..BLINK_TICKS-1.
  - In EDIT, each tick advances the counter; at BLINK_TICKS-1 the counter wraps and blink_phase toggles.
  - Entering EDIT, or any accepted up/down, sets blink_phase=1 and clears the counter.
- digit_on: all 1 outside EDIT. In EDIT, the selected digit's bit = blink_phase and the other bits = 1.
- Reset, including mid-edit: state IDLE, edit_time=0x0000, editing=0, commit=0, digit_on=4'b1111, blink_phase=1, counter=0. No commit strobe results from a reset.

## Timing
- All outputs are registered except digit_on, which is combinational from state, pos and blink_phase.
- edit_start sampled at edge N: editing=1 from N.
- up/down sampled at edge N: edit_time reflects the change after N (1-cycle latency).
- edit_done sampled at edge N: commit=1 and editing=0 for cycle N..N+1. edit_time resumes tracking cur_time from edge N+1.
- pos changes take effect on digit_on immediately and on the next up/down edge.
- Inputs are already synchronized single-cycle pulses; no internal edge detection.

## Test plan
- Reset, then edit_start with cur_time=0x1259, pos=3, up -> edit_time=0x1250; edit_done -> commit high for exactly 1 cycle with 0x1250, then editing=0.
- Starting from 0x1930, pos=0, up -> 0x2330 (Hu clamped); up again -> 0x0330; down -> 0x2330.
- Starting from 0x2300, pos=1, up -> 0x2000; down -> 0x2300. pos=2, down from Mt=0 -> 0x2350.
- up and down asserted together -> edit_time unchanged. edit_done with up in the same cycle -> commit value excludes the increment.
- BLINK_TICKS=2, pos=1, continuous tick -> digit_on alternates 1111/1011 every 2 ticks. An up pulse forces 1111 and restarts the count.
- reset asserted mid-EDIT after edits -> next cycle editing=0, commit never asserted, edit_time=0x0000. A following cycle in IDLE tracks cur_time.
